// File: rtl/doorlock_ctrl_pkg.sv
// Shared types and widths for the doorlock supervisor and its timer.
// State encoding is fixed so external debug tools can decode it.
package doorlock_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int FAIL_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Saturating increment of the consecutive-failure counter.
    function automatic logic [FAIL_W-1:0] fail_sat_inc(
        input logic [FAIL_W-1:0] cnt,
        input logic [FAIL_W-1:0] max_cnt
    );
        logic [FAIL_W-1:0] res;
        if (cnt >= max_cnt) begin
            res = max_cnt;
        end else begin
            res = cnt + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/doorlock_ctrl_timer.sv
// Loadable down-counter shared by every timed state of doorlock_ctrl.
// With DOORLOCK_CTRL_ALARM_EN defined the next count is exported for the alarm.
module doorlock_ctrl_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
`ifdef DOORLOCK_CTRL_ALARM_EN
    output logic [CNT_W-1:0] count_next,
`endif
    output logic             expire
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next count: a load wins, otherwise count down and hold at zero.
    always_comb begin
        count_nxt_s = count_r;
        if (load) begin
            count_nxt_s = load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    // Expiry is flagged on the last cycle of a loaded interval.
    assign expire = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

`ifdef DOORLOCK_CTRL_ALARM_EN
    assign count_next = count_nxt_s;
`endif

endmodule

// File: rtl/doorlock_ctrl.sv
// Supervisor around the doorlock code checker: key gating, entry timeout,
// unlock window and failure lockout. DOORLOCK_CTRL_ALARM_EN enables the alarm.
module doorlock_ctrl
    import doorlock_ctrl_pkg::*;
#(
    parameter int UNLOCK_CYCLES  = 50,
    parameter int ENTRY_TIMEOUT  = 100,
    parameter int LOCKOUT_CYCLES = 200,
    parameter int MAX_FAILS      = 3,
    parameter int CNT_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        key_num,
    input  logic              key_x,
    input  logic              pass_ok,
    input  logic              pass_fail,
    output logic [9:0]        lock_num,
    output logic              lock_x,
    output logic              lock_rst_n,
    output logic              unlock,
    output logic              locked_out,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic              alarm
);

    localparam logic [CNT_W-1:0]  UNLOCK_LD  = CNT_W'(UNLOCK_CYCLES);
    localparam logic [CNT_W-1:0]  ENTRY_LD   = CNT_W'(ENTRY_TIMEOUT);
    localparam logic [CNT_W-1:0]  LOCKOUT_LD = CNT_W'(LOCKOUT_CYCLES);
    localparam logic [FAIL_W-1:0] MAX_FAILS_C = FAIL_W'(MAX_FAILS);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [FAIL_W-1:0] fail_r;
    logic [FAIL_W-1:0] fail_nxt_s;
    logic [FAIL_W-1:0] fail_inc_s;
    logic [9:0]        lock_num_r;
    logic              lock_x_r;
    logic              lock_rst_n_r;
    logic              unlock_r;
    logic              locked_out_r;
    logic              gate_s;
    logic              tmr_load_s;
    logic [CNT_W-1:0]  tmr_load_val_s;
    logic              tmr_expire_s;
`ifdef DOORLOCK_CTRL_ALARM_EN
    logic [CNT_W-1:0]  tmr_next_s;
    logic              alarm_r;
`endif

    doorlock_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load_s),
        .load_val   (tmr_load_val_s),
`ifdef DOORLOCK_CTRL_ALARM_EN
        .count_next (tmr_next_s),
`endif
        .expire     (tmr_expire_s)
    );

    assign fail_inc_s = fail_sat_inc(fail_r, MAX_FAILS_C);
    assign gate_s     = (state_r == ST_IDLE) || (state_r == ST_ENTRY);

    // Next-state, failure accounting and timer loads.
    always_comb begin
        state_nxt_s    = state_r;
        fail_nxt_s     = fail_r;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (key_x) begin
                    state_nxt_s    = ST_ENTRY;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = ENTRY_LD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                // A simultaneous ok+fail pair is a failure; any pulse beats timeout.
                if (pass_fail) begin
                    fail_nxt_s = fail_inc_s;
                    if (fail_inc_s == MAX_FAILS_C) begin
                        state_nxt_s    = ST_LOCKOUT;
                        tmr_load_s     = 1'b1;
                        tmr_load_val_s = LOCKOUT_LD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (pass_ok) begin
                    state_nxt_s    = ST_OPEN;
                    fail_nxt_s     = {FAIL_W{1'b0}};
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = UNLOCK_LD;
                end else if (tmr_expire_s) begin
                    state_nxt_s = ST_CLEAR;
                    fail_nxt_s  = fail_inc_s;
                end else begin
                    state_nxt_s = ST_ENTRY;
                end
            end
            ST_CLEAR: begin
                if (fail_r == MAX_FAILS_C) begin
                    state_nxt_s    = ST_LOCKOUT;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = LOCKOUT_LD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (tmr_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_expire_s) begin
                    state_nxt_s = ST_IDLE;
                    fail_nxt_s  = {FAIL_W{1'b0}};
                end else begin
                    state_nxt_s = ST_LOCKOUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                fail_nxt_s  = {FAIL_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            fail_r       <= {FAIL_W{1'b0}};
            lock_num_r   <= 10'd0;
            lock_x_r     <= 1'b0;
            lock_rst_n_r <= 1'b0;
            unlock_r     <= 1'b0;
            locked_out_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            fail_r       <= fail_nxt_s;
            lock_num_r   <= gate_s ? key_num : 10'd0;
            lock_x_r     <= gate_s ? key_x : 1'b0;
            lock_rst_n_r <= (state_nxt_s != ST_CLEAR);
            unlock_r     <= (state_nxt_s == ST_OPEN);
            locked_out_r <= (state_nxt_s == ST_LOCKOUT);
        end
    end

`ifdef DOORLOCK_CTRL_ALARM_EN
    // Alarm follows timer bit 4 while locked out, giving a 16-cycle toggle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            alarm_r <= 1'b0;
        end else if (state_nxt_s == ST_LOCKOUT) begin
            alarm_r <= tmr_next_s[4];
        end else begin
            alarm_r <= 1'b0;
        end
    end
    assign alarm = alarm_r;
`else
    assign alarm = 1'b0;
`endif

    assign lock_num   = lock_num_r;
    assign lock_x     = lock_x_r;
    assign lock_rst_n = lock_rst_n_r;
    assign unlock     = unlock_r;
    assign locked_out = locked_out_r;
    assign fail_cnt   = fail_r;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Randomised and directed bench for doorlock_ctrl: a queue of expected
// output vectors is filled by the driver and drained by an independent monitor.
module tb_doorlock_ctrl;

    localparam int UNLOCK_CYCLES  = 50;
    localparam int ENTRY_TIMEOUT  = 100;
    localparam int LOCKOUT_CYCLES = 200;
    localparam int MAX_FAILS      = 3;
    localparam int CNT_W          = 8;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_CLEAR = 3, M_LOCK = 4;

    typedef struct packed {
        logic [9:0] num;
        logic       x;
        logic       rst_n;
        logic       unlock;
        logic       locked_out;
        logic [1:0] fails;
        logic       alarm;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] key_num = 10'd0;
    logic       key_x = 1'b0;
    logic       pass_ok = 1'b0;
    logic       pass_fail = 1'b0;
    logic [9:0] lock_num;
    logic       lock_x;
    logic       lock_rst_n;
    logic       unlock;
    logic       locked_out;
    logic [1:0] fail_cnt;
    logic       alarm;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    // behavioural reference state: which mode, how long in it, failures so far
    int m_mode = M_IDLE;
    int m_elapsed = 0;
    int m_fails = 0;

    // simple model of the downstream doorlock checker (code 4, 9)
    bit dl_en = 1'b0;
    bit dl_active = 1'b0;
    bit dl_ok_pend = 1'b0;
    bit dl_fail_pend = 1'b0;
    int dl_digits[$];

    doorlock_ctrl #(
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .ENTRY_TIMEOUT  (ENTRY_TIMEOUT),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .MAX_FAILS      (MAX_FAILS),
        .CNT_W          (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_num    (key_num),
        .key_x      (key_x),
        .pass_ok    (pass_ok),
        .pass_fail  (pass_fail),
        .lock_num   (lock_num),
        .lock_x     (lock_x),
        .lock_rst_n (lock_rst_n),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .alarm      (alarm)
    );

    always #5 clock = ~clock;

    task automatic enter_mode(input int mode);
        m_mode = mode;
        m_elapsed = 0;
    endtask

    task automatic count_failure();
        m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
    endtask

    // One clock of the reference: returns the outputs expected after the edge.
    task automatic model_step(input logic rst, input logic [9:0] num, input logic x,
                              input logic ok, input logic fl);
        exp_t e;
        bit   keys_open;
        e = '0;
        if (!rst) begin
            enter_mode(M_IDLE);
            m_fails = 0;
        end else begin
            keys_open = (m_mode == M_IDLE) || (m_mode == M_ENTRY);
            e.num = keys_open ? num : 10'd0;
            e.x   = keys_open ? x : 1'b0;
            m_elapsed++;
            case (m_mode)
                M_IDLE:  if (x) enter_mode(M_ENTRY);
                M_ENTRY: begin
                    if (fl) begin
                        count_failure();
                        enter_mode((m_fails == MAX_FAILS) ? M_LOCK : M_IDLE);
                    end else if (ok) begin
                        m_fails = 0;
                        enter_mode(M_OPEN);
                    end else if (m_elapsed == ENTRY_TIMEOUT) begin
                        count_failure();
                        enter_mode(M_CLEAR);
                    end
                end
                M_CLEAR: enter_mode((m_fails == MAX_FAILS) ? M_LOCK : M_IDLE);
                M_OPEN:  if (m_elapsed == UNLOCK_CYCLES) enter_mode(M_IDLE);
                M_LOCK: begin
                    if (m_elapsed == LOCKOUT_CYCLES) begin
                        m_fails = 0;
                        enter_mode(M_IDLE);
                    end
                end
                default: enter_mode(M_IDLE);
            endcase
            e.rst_n      = (m_mode != M_CLEAR);
            e.unlock     = (m_mode == M_OPEN);
            e.locked_out = (m_mode == M_LOCK);
            e.fails      = 2'(m_fails);
`ifdef DOORLOCK_CTRL_ALARM_EN
            // remaining lockout time is LOCKOUT_CYCLES - elapsed; alarm is its bit 4
            e.alarm = (m_mode == M_LOCK) ? 1'(((LOCKOUT_CYCLES - m_elapsed) >> 4) & 1) : 1'b0;
`endif
        end
        exp_q.push_back(e);
    endtask

    // Doorlock model observes what the DUT forwards and schedules a result pulse.
    task automatic dl_eval();
        if (lock_rst_n !== 1'b1) begin
            dl_active = 1'b0;
            dl_digits.delete();
        end else if (lock_x === 1'b1) begin
            if (!dl_active) begin
                dl_active = 1'b1;
                dl_digits.delete();
            end else begin
                if (dl_digits.size() == 2 && dl_digits[0] == 4 && dl_digits[1] == 9)
                    dl_ok_pend = 1'b1;
                else
                    dl_fail_pend = 1'b1;
                dl_active = 1'b0;
            end
        end else if (dl_active) begin
            for (int b = 0; b < 10; b++)
                if (lock_num[b] === 1'b1) dl_digits.push_back(b);
        end
    endtask

    task automatic step(input logic rst, input logic [9:0] num, input logic x,
                        input logic ok, input logic fl);
        logic r_ok, r_fl;
        @(negedge clock);
        r_ok = ok | dl_ok_pend;
        r_fl = fl | dl_fail_pend;
        dl_ok_pend = 1'b0;
        dl_fail_pend = 1'b0;
        if (dl_en) dl_eval();
        reset = rst;
        key_num = num;
        key_x = x;
        pass_ok = r_ok;
        pass_fail = r_fl;
        model_step(rst, num, x, r_ok, r_fl);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic digit(input int d);
        logic [9:0] oh;
        oh = 10'd1 << d;
        step(1'b1, oh, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic enter_code(input int d0, input int d1);
        step(1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        digit(d0);
        digit(d1);
        step(1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
        idle(3);
    endtask

    // Monitor: compares every registered output vector the DUT presents.
    initial begin : monitor
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clock);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {lock_num, lock_x, lock_rst_n, unlock, locked_out, fail_cnt, alarm};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL outputs @cycle %0d: got num=%h x=%b rst_n=%b unlock=%b lockout=%b fails=%0d alarm=%b, want num=%h x=%b rst_n=%b unlock=%b lockout=%b fails=%0d alarm=%b",
                             cycle, act.num, act.x, act.rst_n, act.unlock, act.locked_out, act.fails, act.alarm,
                             e.num, e.x, e.rst_n, e.unlock, e.locked_out, e.fails, e.alarm);
                end
            end
        end
    end

    initial begin : driver
        logic [9:0] rnum;
        int         pdiv;
        // reset, then a correct code through the doorlock model
        repeat (3) step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        dl_en = 1'b1;
        idle(2);
        enter_code(4, 9);
        idle(60);
        // three wrong codes, strobes pressed during the lockout
        enter_code(1, 2);
        enter_code(9, 4);
        enter_code(4, 8);
        for (int k = 0; k < 195; k++) begin
            rnum = ($urandom_range(1) == 0) ? (10'd1 << $urandom_range(9)) : 10'd0;
            step(1'b1, rnum, ($urandom_range(2) == 0), 1'b0, 1'b0);
        end
        idle(15);
        // entry timeout with no result
        step(1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
        idle(105);
        // both pulses together counts as a failure
        dl_en = 1'b0;
        step(1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 10'd0, 1'b0, 1'b1, 1'b1);
        idle(3);
        // third failure by timeout goes through CLEAR into lockout; reset mid-lockout
        step(1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
        idle(110);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // result pulse on the timeout cycle wins; then reset mid-open
        step(1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
        idle(ENTRY_TIMEOUT - 1);
        step(1'b1, 10'd0, 1'b0, 1'b1, 1'b0);
        idle(20);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        idle(3);
        // randomised traffic with varying result-pulse density
        for (int blk = 0; blk < 6; blk++) begin
            pdiv = (blk % 2 == 0) ? 15 : 127;
            for (int k = 0; k < 500; k++) begin
                rnum = ($urandom_range(3) == 0) ? (10'd1 << $urandom_range(9)) : 10'd0;
                step(($urandom_range(299) != 0), rnum, ($urandom_range(7) == 0),
                     ($urandom_range(pdiv) == 0), ($urandom_range(pdiv) == 0));
            end
        end
        idle(1);
        @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
